// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier controller: state encoding,
// default operand width and the step counter width function.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Enough bits to hold every value 0..width inclusive.
    function automatic int cw_f(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_ctrl_fsm_if.sv
// Controller <-> datapath/host bundle: start/abort handshake, datapath status in,
// command strobes and progress out. master = controller side, slave = environment side.
interface mult_ctrl_fsm_if #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);
    localparam int CW = mult_pkg::cw_f(WIDTH);

    logic          start;
    logic          abort;
    logic          b_lsb;
    logic          b_zero;
    logic          load;
    logic          add_en;
    logic          shift_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] step;

    modport master (
        input  start, abort, b_lsb, b_zero,
        output load, add_en, shift_en, busy, done, step
    );

    modport slave (
        output start, abort, b_lsb, b_zero,
        input  load, add_en, shift_en, busy, done, step
    );

endinterface

// File: rtl/step_counter.sv
// Iteration counter: clear has priority, increments on en and saturates at WIDTH.
// One-cycle update latency; no backpressure, holds its value when idle.
module step_counter
    import mult_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = cw_f(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX_COUNT)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mult_ctrl_fsm.sv
// Shift-and-add multiplier sequencer; done 2*WIDTH+2 cycles after start (optional MULT_CTRL_EARLY_EXIT_EN
// ends on b_zero); start ignored while busy, abort returns to IDLE from any state.
module mult_ctrl_fsm
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    mult_ctrl_fsm_if.master bus
);

    localparam int CW = cw_f(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] step_q;
    logic          cnt_clr;
    logic          cnt_en;
    logic          load;
    logic          add_en;
    logic          shift_en;
    logic          busy;
    logic          done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort overrides every transition and also suppresses the counter update,
    // so an aborted run leaves step at the iteration it reached.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                busy    = 1'b1;
                cnt_clr = !bus.abort;
                state_d = bus.abort ? ST_IDLE : ST_CALC;
            end
            ST_CALC: begin
                busy    = 1'b1;
                add_en  = bus.b_lsb;
                state_d = ST_SHIFT;
`ifdef MULT_CTRL_EARLY_EXIT_EN
                if (bus.b_zero && !bus.abort) begin
                    add_en  = 1'b0;
                    state_d = ST_DONE;
                end
`endif
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                cnt_en   = !bus.abort;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (step_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifndef MULT_CTRL_EARLY_EXIT_EN
    logic unused_b_zero;
    assign unused_b_zero = bus.b_zero;
`endif

    step_counter #(
        .WIDTH (WIDTH)
    ) u_step_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (step_q)
    );

    assign bus.load     = load;
    assign bus.add_en   = add_en;
    assign bus.shift_en = shift_en;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.step     = step_q;

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Scoreboard bench for mult_ctrl_fsm at WIDTH 8, 4 and 16: stimulus queues expected
// command/done/busy-end events, a negedge monitor pops and compares them.
module tb_mult_ctrl_fsm;

    localparam int K_LOAD  = 0;
    localparam int K_ADD   = 1;
    localparam int K_SHIFT = 2;
    localparam int K_DONE  = 3;
    localparam int K_BEND  = 4;

    typedef struct {
        int dut;
        int cyc;
        int kind;
        int val;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    evt_t  exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    blen[3] = '{0, 0, 0};
    int    overlap_cnt = 0;

    logic  probe_req = 1'b0;
    int    probe_dut = 0;
    int    probe_exp = 0;
    string probe_name = "";
    logic  fin_req = 1'b0;
    logic  fin_done = 1'b0;

    mult_ctrl_fsm_if #(.WIDTH(8))  if8 ();
    mult_ctrl_fsm_if #(.WIDTH(4))  if4 ();
    mult_ctrl_fsm_if #(.WIDTH(16)) if16 ();

    mult_ctrl_fsm #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
    mult_ctrl_fsm #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
    mult_ctrl_fsm #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_LOAD:  return "load";
            K_ADD:   return "add_en";
            K_SHIFT: return "shift_en";
            K_DONE:  return "done";
            default: return "busy_end";
        endcase
    endfunction

    function automatic int snap(input logic ld, input logic ad, input logic sh,
                                input logic bs, input logic dn, input int stp);
        return (stp << 5) | int'({ld, ad, sh, bs, dn});
    endfunction

    task automatic push(input int d, input int c, input int k, input int v);
        evt_t e;
        e.dut = d; e.cyc = c; e.kind = k; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic emit(input int d, input int k, input int v);
        evt_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL evt: got dut%0d %s@%0d val=%0d, required no event", d, kname(k), cyc, v);
        end else begin
            e = exp_q.pop_front();
            if (e.dut != d || e.cyc != cyc || e.kind != k || e.val != v) begin
                fails++;
                $display("FAIL evt: got dut%0d %s@%0d val=%0d, required dut%0d %s@%0d val=%0d",
                         d, kname(k), cyc, v, e.dut, kname(e.kind), e.cyc, e.val);
            end
        end
    endtask

    task automatic observe(input int d, input logic ld, input logic ad, input logic sh,
                           input logic dn, input logic bs, input int stp);
        if (int'(ld) + int'(ad) + int'(sh) + int'(dn) > 1) overlap_cnt++;
        if (ld) emit(d, K_LOAD, 0);
        if (ad) emit(d, K_ADD, 0);
        if (sh) emit(d, K_SHIFT, 0);
        if (dn) emit(d, K_DONE, stp);
        if (bs) begin
            blen[d]++;
        end else if (blen[d] > 0) begin
            emit(d, K_BEND, blen[d]);
            blen[d] = 0;
        end
    endtask

    // Monitor: the only process that makes comparisons.
    always @(negedge clk) begin
        int s;
        observe(0, if8.load,  if8.add_en,  if8.shift_en,  if8.done,  if8.busy,  int'(if8.step));
        observe(1, if4.load,  if4.add_en,  if4.shift_en,  if4.done,  if4.busy,  int'(if4.step));
        observe(2, if16.load, if16.add_en, if16.shift_en, if16.done, if16.busy, int'(if16.step));
        if (probe_req) begin
            case (probe_dut)
                0:       s = snap(if8.load,  if8.add_en,  if8.shift_en,  if8.busy,  if8.done,  int'(if8.step));
                1:       s = snap(if4.load,  if4.add_en,  if4.shift_en,  if4.busy,  if4.done,  int'(if4.step));
                default: s = snap(if16.load, if16.add_en, if16.shift_en, if16.busy, if16.done, int'(if16.step));
            endcase
            tests++;
            if (s != probe_exp) begin
                fails++;
                $display("FAIL probe %s: got step=%0d flags(ld,add,sh,busy,done)=%05b, required step=%0d flags=%05b",
                         probe_name, s >> 5, s[4:0], probe_exp >> 5, probe_exp[4:0]);
            end
        end
        if (fin_req && !fin_done) begin
            tests++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL leftover: %0d expected events never seen, first dut%0d %s@%0d",
                         exp_q.size(), exp_q[0].dut, kname(exp_q[0].kind), exp_q[0].cyc);
            end
            tests++;
            if (overlap_cnt != 0) begin
                fails++;
                $display("FAIL exclusive: got %0d overlapping command cycles, required 0", overlap_cnt);
            end
            fin_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        probe_req = 1'b0;
    endtask

    task automatic probe(input int d, input string nm, input int stp, input logic [4:0] fl);
        probe_dut  = d;
        probe_name = nm;
        probe_exp  = (stp << 5) | int'(fl);
        probe_req  = 1'b1;
    endtask

    initial begin
        int t0;
        logic [7:0] pat;
        pat = 8'b1000_1101;  // bit i = b_lsb seen in CALC of iteration i: 1,0,1,1,0,0,0,1
        {if8.start,  if8.abort,  if8.b_lsb,  if8.b_zero}  = 4'b0;
        {if4.start,  if4.abort,  if4.b_lsb,  if4.b_zero}  = 4'b0;
        {if16.start, if16.abort, if16.b_lsb, if16.b_zero} = 4'b0;

        // Reset state of every instance
        tick();
        probe(0, "reset_w8", 0, 5'b00000);  tick();
        probe(1, "reset_w4", 0, 5'b00000);  tick();
        probe(2, "reset_w16", 0, 5'b00000); tick();
        rst = 1'b0;
        tick();

        // WIDTH=8: async reset in the CALC of iteration 3 (cycle 8)
        t0 = cyc;
        push(0, t0 + 1, K_LOAD, 0);
        push(0, t0 + 2, K_ADD, 0);   push(0, t0 + 3, K_SHIFT, 0);
        push(0, t0 + 4, K_ADD, 0);   push(0, t0 + 5, K_SHIFT, 0);
        push(0, t0 + 6, K_ADD, 0);   push(0, t0 + 7, K_SHIFT, 0);
        push(0, t0 + 8, K_BEND, 7);
        if8.start = 1'b1; if8.b_lsb = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        probe(0, "rst_mid_calc", 0, 5'b00000);
        tick();
        rst = 1'b0;
        tick();

        // WIDTH=8: full run with b_lsb pattern 1,0,1,1,0,0,0,1
        t0 = cyc;
        for (int k = 1; k <= 19; k++) begin
            if (k == 1) push(0, t0 + k, K_LOAD, 0);
            if (k inside {2, 6, 8, 16}) push(0, t0 + k, K_ADD, 0);
            if (k >= 3 && k <= 17 && (k % 2) == 1) push(0, t0 + k, K_SHIFT, 0);
            if (k == 18) push(0, t0 + k, K_DONE, 8);
            if (k == 19) push(0, t0 + k, K_BEND, 18);
        end
        for (int k = 0; k <= 20; k++) begin
            if8.start = (k == 0);
            if8.b_lsb = (k >= 2 && k <= 16 && (k % 2) == 0) ? pat[(k - 2) / 2] : 1'b0;
            tick();
        end
        probe(0, "step_hold_w8", 8, 5'b00000);
        tick();

        // WIDTH=4: start held high, back-to-back runs every 11 cycles
        t0 = cyc;
        for (int r = 0; r < 3; r++) begin
            push(1, t0 + 11 * r + 1, K_LOAD, 0);
            for (int s = 0; s < 4; s++) push(1, t0 + 11 * r + 3 + 2 * s, K_SHIFT, 0);
            push(1, t0 + 11 * r + 10, K_DONE, 4);
            push(1, t0 + 11 * r + 11, K_BEND, 10);
        end
        for (int k = 0; k <= 36; k++) begin
            if4.start = (k < 33);
            tick();
        end

        // WIDTH=8: abort in SHIFT cycle 7, then start+abort together in IDLE
        t0 = cyc;
        push(0, t0 + 1, K_LOAD, 0);
        push(0, t0 + 3, K_SHIFT, 0);
        push(0, t0 + 5, K_SHIFT, 0);
        push(0, t0 + 7, K_SHIFT, 0);
        push(0, t0 + 8, K_BEND, 7);
        for (int k = 0; k <= 12; k++) begin
            if8.start = (k == 0) || (k == 8);
            if8.abort = (k == 7) || (k == 8);
            if (k == 9) probe(0, "abort_idle", 2, 5'b00000);
            tick();
        end

        // WIDTH=16: start pulses while busy are ignored
        t0 = cyc;
        push(2, t0 + 1, K_LOAD, 0);
        for (int k = 3; k <= 33; k += 2) push(2, t0 + k, K_SHIFT, 0);
        push(2, t0 + 34, K_DONE, 16);
        push(2, t0 + 35, K_BEND, 34);
        for (int k = 0; k <= 38; k++) begin
            if16.start = (k == 0) || (k == 5) || (k == 20);
            tick();
        end

        // WIDTH=8: b_zero at the third CALC (cycle 6), b_lsb held high
        t0 = cyc;
`ifdef MULT_CTRL_EARLY_EXIT_EN
        push(0, t0 + 1, K_LOAD, 0);
        push(0, t0 + 2, K_ADD, 0);  push(0, t0 + 3, K_SHIFT, 0);
        push(0, t0 + 4, K_ADD, 0);  push(0, t0 + 5, K_SHIFT, 0);
        push(0, t0 + 7, K_DONE, 2);
        push(0, t0 + 8, K_BEND, 7);
`else
        for (int k = 1; k <= 19; k++) begin
            if (k == 1) push(0, t0 + k, K_LOAD, 0);
            if (k >= 2 && k <= 16 && (k % 2) == 0) push(0, t0 + k, K_ADD, 0);
            if (k >= 3 && k <= 17 && (k % 2) == 1) push(0, t0 + k, K_SHIFT, 0);
            if (k == 18) push(0, t0 + k, K_DONE, 8);
            if (k == 19) push(0, t0 + k, K_BEND, 18);
        end
`endif
        for (int k = 0; k <= 22; k++) begin
            if8.start  = (k == 0);
            if8.b_lsb  = 1'b1;
            if8.b_zero = (k == 6);
            tick();
        end
        if8.b_lsb = 1'b0;
        tick();

        fin_req = 1'b1;
        repeat (2) tick();
        if (!fin_done) begin
            $display("FAIL monitor: final checks not reached");
            $fatal(1, "monitor stalled");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
